// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC121S101 SPI serializer.
// Frame word on the wire, MSB first: {2'b00, pd[1:0], data[11:0]}.
// Power-down codes are only driven onto the wire when DAC_SPI_PD_EN is defined.
package dac_spi_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 12;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0]        pd,
                                                       input logic [DATA_W-1:0] data);
        return {2'b00, pd, data};
    endfunction

endpackage

// File: rtl/dac_spi_serializer_if.sv
// Sample stream from the waveform generator into the DAC serializer.
// Pure wiring, no latency; s_ready is the only backpressure path.
// DAC_SPI_PD_EN adds the 2-bit power-down mode alongside each sample.
interface dac_spi_serializer_if;
    import dac_spi_pkg::*;

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

`ifdef DAC_SPI_PD_EN
    logic [1:0]        pd;

    modport master (output s_data, output s_valid, output pd, input s_ready);
    modport slave  (input s_data, input s_valid, input pd, output s_ready);
`else
    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
`endif

endinterface

// File: rtl/dac_spi_tick_gen.sv
// Half-period tick generator for SCLK: tick every CLK_DIV enabled cycles.
// Latency: first tick CLK_DIV cycles after enable rises from a cleared count.
// No backpressure; clr wins over en and restarts the count at frame start.
module dac_spi_tick_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk_10MHz,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk_10MHz or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dac_spi_serializer.sv
// Serializes 12-bit samples into 16-bit SPI write frames for a DAC121S101-class DAC.
// Latency: SYNC falls 1 cycle after accept; period 1+32*CLK_DIV+GAP_CYCLES cycles.
// s_ready is low for the whole frame and gap; DAC_SPI_PD_EN enables pd bits 13:12.
module dac_spi_serializer
    import dac_spi_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk_10MHz,
    input  logic                 reset_n,
    dac_spi_serializer_if.slave  s_if,
    output logic                 frame_done,
    output logic                 dw_sclk,
    output logic                 dw_sync,
    output logic                 dw_mosi
);

    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [4:0]    BIT_LAST = 5'd15;

    state_t               state, state_d;
    logic [FRAME_W-1:0]   shreg, shreg_d;
    logic [4:0]           bit_cnt, bit_cnt_d;
    logic [GW-1:0]        gap_cnt, gap_cnt_d;
    logic                 s_ready, s_ready_d;
    logic                 sync_d, sclk_d, done_d;
    logic                 accept, shift_en, tick, last_rise;
    logic [1:0]           pd_sel;

`ifdef DAC_SPI_PD_EN
    assign pd_sel = s_if.pd;
`else
    assign pd_sel = PD_NORMAL;
`endif

    assign accept    = (state == IDLE) && s_ready && s_if.s_valid;
    assign shift_en  = (state == SHIFT);
    // The 16th rising edge coincides with SYNC release, so it ends the frame.
    assign last_rise = tick && !dw_sclk && (bit_cnt == BIT_LAST);

    assign s_if.s_ready = s_ready;
    assign dw_mosi      = shreg[FRAME_W-1];

    dac_spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_10MHz (clk_10MHz),
        .reset_n   (reset_n),
        .en        (shift_en),
        .clr       (accept),
        .tick      (tick)
    );

    always_ff @(posedge clk_10MHz or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            s_ready    <= 1'b0;
            dw_sync    <= 1'b1;
            dw_sclk    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            bit_cnt    <= bit_cnt_d;
            gap_cnt    <= gap_cnt_d;
            s_ready    <= s_ready_d;
            dw_sync    <= sync_d;
            dw_sclk    <= sclk_d;
            frame_done <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_rise) state_d = GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        gap_cnt_d = gap_cnt;
        s_ready_d = 1'b0;
        sync_d    = dw_sync;
        sclk_d    = dw_sclk;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                s_ready_d = !accept;
                sync_d    = 1'b1;
                sclk_d    = 1'b1;
                if (accept) begin
                    shreg_d   = build_frame(pd_sel, s_if.s_data);
                    bit_cnt_d = '0;
                    sync_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sclk_d = !dw_sclk;
                    // MOSI only advances on rising SCLK, keeping it stable across the falling edge.
                    if (!dw_sclk) begin
                        if (bit_cnt == BIT_LAST) begin
                            sync_d    = 1'b1;
                            done_d    = 1'b1;
                            gap_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt + 5'd1;
                            shreg_d   = shreg << 1;
                        end
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt + GW'(1);
                s_ready_d = (gap_cnt == GAP_LAST);
            end
            default: begin
                sync_d = 1'b1;
                sclk_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Randomized bench for dac_spi_serializer: two instances (default and slow timing)
// decoded from the pins and scored against an arithmetic model of the frame rules.
module tb_dac_spi_serializer;

    localparam int D0 = 1;
    localparam int G0 = 2;
    localparam int D1 = 3;
    localparam int G1 = 4;

    typedef struct {
        int dut;
        int cyc;
        int word;
    } acc_t;

    typedef struct {
        int dut;
        int word;
        int low;
        int falls;
        int end_cyc;
        bit done;
        bit sclk_hi;
        bit mosi_ok;
        int hmin;
        int hmax;
    } frm_t;

    logic        clk = 1'b0;
    logic [1:0]  rst_n = 2'b00;
    logic [11:0] s_data [2];
    logic [1:0]  pd [2];
    logic [1:0]  s_valid = 2'b00;
    logic [1:0]  s_ready;
    logic [1:0]  frame_done, dw_sclk, dw_sync, dw_mosi;

    int n_checks = 0;
    int n_pass   = 0;
    int stray    = 0;
    int cyc      = 0;

    acc_t acc_q [$];
    frm_t frm_q [$];

    bit in_frm [2];
    bit prev_sclk [2];
    bit prev_mosi [2];
    bit ok_sclk [2];
    bit ok_mosi [2];
    int low [2];
    int nf [2];
    int wd [2];
    int half [2];
    int hmin [2];
    int hmax [2];

    always #5 clk = ~clk;

    dac_spi_serializer_if if0 ();
    dac_spi_serializer_if if1 ();

    assign if0.s_data  = s_data[0];
    assign if0.s_valid = s_valid[0];
    assign if1.s_data  = s_data[1];
    assign if1.s_valid = s_valid[1];
    assign s_ready[0]  = if0.s_ready;
    assign s_ready[1]  = if1.s_ready;
`ifdef DAC_SPI_PD_EN
    assign if0.pd = pd[0];
    assign if1.pd = pd[1];
`endif

    dac_spi_serializer #(.CLK_DIV(D0), .GAP_CYCLES(G0)) dut0 (
        .clk_10MHz (clk),
        .reset_n   (rst_n[0]),
        .s_if      (if0.slave),
        .frame_done(frame_done[0]),
        .dw_sclk   (dw_sclk[0]),
        .dw_sync   (dw_sync[0]),
        .dw_mosi   (dw_mosi[0])
    );

    dac_spi_serializer #(.CLK_DIV(D1), .GAP_CYCLES(G1)) dut1 (
        .clk_10MHz (clk),
        .reset_n   (rst_n[1]),
        .s_if      (if1.slave),
        .frame_done(frame_done[1]),
        .dw_sclk   (dw_sclk[1]),
        .dw_sync   (dw_sync[1]),
        .dw_mosi   (dw_mosi[1])
    );

    function automatic int div_of(int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic int gap_of(int i);
        return (i == 0) ? G0 : G1;
    endfunction

    // Reference word: the 12-bit sample plus the power-down code weighted at bit 12.
    function automatic int exp_word(logic [11:0] d, logic [1:0] p);
`ifdef DAC_SPI_PD_EN
        return int'(d) + int'(p) * 4096;
`else
        return int'(d) + 0 * int'(p);
`endif
    endfunction

    task automatic check(string tag, int unsigned got, int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Accept events are taken at the active edge, before the DUT updates s_ready.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n[i] && s_valid[i] && s_ready[i])
                acc_q.push_back('{i, cyc, exp_word(s_data[i], pd[i])});
        end
        cyc++;
    end

    // Pin decoder: rebuilds each frame from SYNC/SCLK/MOSI as the DAC would see it.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                in_frm[i]    = 1'b0;
                prev_sclk[i] = 1'b1;
            end else if (!dw_sync[i]) begin
                if (!in_frm[i]) begin
                    in_frm[i]  = 1'b1;
                    low[i]     = 1;
                    nf[i]      = 0;
                    wd[i]      = 0;
                    ok_sclk[i] = dw_sclk[i];
                    ok_mosi[i] = 1'b1;
                    half[i]    = 1;
                    hmin[i]    = 1000;
                    hmax[i]    = 0;
                end else begin
                    low[i]++;
                    if (dw_sclk[i] == prev_sclk[i]) begin
                        half[i]++;
                    end else begin
                        if (half[i] < hmin[i]) hmin[i] = half[i];
                        if (half[i] > hmax[i]) hmax[i] = half[i];
                        half[i] = 1;
                    end
                    if (prev_sclk[i] && !dw_sclk[i]) begin
                        wd[i] = (wd[i] << 1) | int'(dw_mosi[i]);
                        nf[i]++;
                    end
                    if (dw_mosi[i] != prev_mosi[i] && !(!prev_sclk[i] && dw_sclk[i]))
                        ok_mosi[i] = 1'b0;
                end
            end else if (in_frm[i]) begin
                if (half[i] < hmin[i]) hmin[i] = half[i];
                if (half[i] > hmax[i]) hmax[i] = half[i];
                frm_q.push_back('{i, wd[i], low[i], nf[i], cyc, frame_done[i],
                                  ok_sclk[i] && dw_sclk[i], ok_mosi[i], hmin[i], hmax[i]});
                in_frm[i] = 1'b0;
            end else if (frame_done[i]) begin
                stray++;
            end
            prev_sclk[i] = dw_sclk[i];
            prev_mosi[i] = dw_mosi[i];
        end
    end

    task automatic send(int i, logic [11:0] d, logic [1:0] p, int idle);
        int t = 0;
        @(negedge clk);
        repeat (idle) @(negedge clk);
        s_data[i]  = d;
        pd[i]      = p;
        s_valid[i] = 1'b1;
        while (!s_ready[i] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", t < 1000, 1);
        @(negedge clk);
        s_valid[i] = 1'b0;
        s_data[i]  = 12'($urandom);
    endtask

    task automatic check_frames(int dut, int n);
        int   t    = 0;
        int   prev = -1;
        int   d    = div_of(dut);
        int   g    = gap_of(dut);
        acc_t a;
        frm_t f;
        while ((frm_q.size() < n || acc_q.size() < n) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("drain", frm_q.size() >= n && acc_q.size() >= n, 1);
        if (frm_q.size() < n || acc_q.size() < n) return;
        for (int k = 0; k < n; k++) begin
            a = acc_q.pop_front();
            f = frm_q.pop_front();
            check("frame_dut",   f.dut, a.dut);
            check("word",        f.word, a.word);
            check("sync_low",    f.low, 32 * d);
            check("done_cycle",  f.end_cyc - a.cyc, 1 + 32 * d);
            check("fall_edges",  f.falls, 16);
            check("frame_done",  f.done, 1);
            check("sclk_at_sync", f.sclk_hi, 1);
            check("mosi_stable", f.mosi_ok, 1);
            check("half_min",    f.hmin, d);
            check("half_max",    f.hmax, d);
            if (prev >= 0) check("spacing", a.cyc - prev >= 1 + 32 * d + g, 1);
            prev = a.cyc;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int t;
        bit ps;
        s_data[0] = '0; s_data[1] = '0;
        pd[0] = '0; pd[1] = '0;

        repeat (5) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("rst_sync", dw_sync[i], 1);
                check("rst_sclk", dw_sclk[i], 1);
                check("rst_mosi", dw_mosi[i], 0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", s_ready[i], 0);
            check("rst_done",  frame_done[i], 0);
        end
        rst_n = 2'b11;
        @(posedge clk);
        #1;
        check("ready_after_rst0", s_ready[0], 1);
        check("ready_after_rst1", s_ready[1], 1);

        send(0, 12'hA5C, 2'b00, 0);
        check_frames(0, 1);

        // Held s_valid: two samples back to back.
        @(negedge clk);
        s_data[0] = 12'hFFF;
        s_valid[0] = 1'b1;
        t = 0;
        while (!s_ready[0] && t < 1000) begin @(negedge clk); t++; end
        @(negedge clk);
        s_data[0] = 12'h000;
        t = 0;
        while (!s_ready[0] && t < 1000) begin @(negedge clk); t++; end
        check("b2b_ready_wait", t < 1000, 1);
        @(negedge clk);
        s_valid[0] = 1'b0;
        if (acc_q.size() >= 2) check("b2b_spacing", acc_q[1].cyc - acc_q[0].cyc, 1 + 32 * D0 + G0);
        else check("b2b_accepts", acc_q.size(), 2);
        check_frames(0, 2);

        send(1, 12'hA5C, 2'b00, 0);
        check_frames(1, 1);

        for (int i = 0; i < 2; i++) begin
            repeat (6) send(i, 12'($urandom), 2'($urandom), $urandom_range(0, 3));
            check_frames(i, 6);
        end

        // Reset asserted after the 7th falling edge abandons the frame.
        send(0, 12'($urandom), 2'($urandom), 0);
        k = 0;
        t = 0;
        ps = dw_sclk[0];
        while (k < 7 && t < 500) begin
            @(posedge clk);
            #1;
            if (ps && !dw_sclk[0]) k++;
            ps = dw_sclk[0];
            t++;
        end
        check("mid_fall_count", k, 7);
        rst_n[0] = 1'b0;
        #1;
        check("mid_rst_sync", dw_sync[0], 1);
        check("mid_rst_sclk", dw_sclk[0], 1);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_sclk_hold", dw_sclk[0], 1);
            check("mid_rst_sync_hold", dw_sync[0], 1);
        end
        check("abort_no_frame", frm_q.size(), 0);
        if (acc_q.size() > 0) void'(acc_q.pop_back());
        rst_n[0] = 1'b1;
        send(0, 12'($urandom), 2'($urandom), 1);
        check_frames(0, 1);

`ifdef DAC_SPI_PD_EN
        send(0, 12'h123, 2'b11, 0);
        check_frames(0, 1);
`endif

        repeat (10) @(negedge clk);
        check("stray_done", stray, 0);
        check("leftover_accepts", acc_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
